// File: rtl/datamem_responder_if.sv
// Data-memory control bundle between the datapath (master) and the responder (slave).
// With DMEM_ACCESS_COUNT_EN defined the bundle also carries the access counters.
interface datamem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Stall;
    logic        Done;
    logic        AccessErr;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] RdCount;
    logic [31:0] WrCount;
`endif

`ifdef DMEM_ACCESS_COUNT_EN
    modport master (
        output MemRead, MemWrite, Funct3, Addr, WrData,
        input  RdData, Stall, Done, AccessErr, RdCount, WrCount
    );
    modport slave (
        input  MemRead, MemWrite, Funct3, Addr, WrData,
        output RdData, Stall, Done, AccessErr, RdCount, WrCount
    );
`else
    modport master (
        output MemRead, MemWrite, Funct3, Addr, WrData,
        input  RdData, Stall, Done, AccessErr
    );
    modport slave (
        input  MemRead, MemWrite, Funct3, Addr, WrData,
        output RdData, Stall, Done, AccessErr
    );
`endif
endinterface

// File: rtl/datamem_responder.sv
// Data-memory responder: byte/half/word access to a word array after LATENCY wait states.
// Optional macro DMEM_ACCESS_COUNT_EN adds good-load / good-store counters.
module datamem_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int LATENCY    = 2
) (
    input logic                 clk,
    input logic                 reset,
    datamem_responder_if.slave  bus
);
    localparam int         WORDS    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [31:0]           rd_data_r;
    logic                  done_r;
    logic                  err_r;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [31:0]           wrdata_q;
    logic                  store_q;

    logic [31:0]           mem [WORDS];

    logic                  req;
    logic                  in_idle;
    logic                  go_resp;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [2:0]            eff_f3;
    logic [31:0]           eff_wrdata;
    logic                  eff_store;
    logic                  eff_err;
    logic [3:0]            eff_be;
    logic [31:0]           eff_lanes;
    logic [31:0]           rd_word;
    logic                  unused_addr_bits;

    function automatic logic access_err(input logic [2:0] f3, input logic st,
                                        input logic [1:0] a);
        logic e;
        case (f3)
            3'b000:         e = 1'b0;
            3'b001:         e = a[0];
            3'b010:         e = (a != 2'b00);
            3'b100, 3'b101: e = st | (f3[0] & a[0]);
            default:        e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so the byte enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] l;
        case (f3[1:0])
            2'b00:   l = {4{d[7:0]}};
            2'b01:   l = {2{d[15:0]}};
            default: l = d;
        endcase
        return l;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0, h};
            3'b010:  r = word;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    assign req     = bus.MemRead | bus.MemWrite;
    assign in_idle = (state == IDLE);

    // With LATENCY=0 the commit edge is also the capture edge, so use live inputs in IDLE.
    assign eff_addr   = in_idle ? bus.Addr[ADDR_WIDTH-1:0] : addr_q;
    assign eff_f3     = in_idle ? bus.Funct3 : funct3_q;
    assign eff_wrdata = in_idle ? bus.WrData : wrdata_q;
    assign eff_store  = in_idle ? bus.MemWrite : store_q;
    assign eff_err    = access_err(eff_f3, eff_store, eff_addr[1:0]);
    assign eff_be     = byte_en(eff_f3, eff_addr[1:0]);
    assign eff_lanes  = store_lanes(eff_f3, eff_wrdata);
    assign rd_word    = mem[eff_addr[ADDR_WIDTH-1:2]];

    assign go_resp = reset && ((in_idle && req && (LATENCY == 0)) ||
                               ((state == WAIT) && (cnt == 4'd1)));

    assign unused_addr_bits = ^bus.Addr[31:ADDR_WIDTH];

    assign bus.Stall     = reset && ((in_idle && req) || (state == WAIT));
    assign bus.Done      = done_r;
    assign bus.RdData    = rd_data_r;
    assign bus.AccessErr = err_r;

    // Request capture: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (in_idle && req) begin
            addr_q   <= bus.Addr[ADDR_WIDTH-1:0];
            funct3_q <= bus.Funct3;
            wrdata_q <= bus.WrData;
            store_q  <= bus.MemWrite;
        end
    end

    // Store commit on the edge entering RESP; the array survives reset.
    always_ff @(posedge clk) begin
        if (go_resp && eff_store && !eff_err) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_be[i]) begin
                    mem[eff_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= eff_lanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rd_data_r <= 32'h0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= go_resp;
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt   <= LAT_INIT;
                        state <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                rd_data_r <= (eff_store || eff_err) ? 32'h0
                                                    : load_extend(rd_word, eff_f3, eff_addr[1:0]);
                err_r     <= eff_err;
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    assign bus.RdCount = rd_count;
    assign bus.WrCount = wr_count;

    // Counts update on the commit edge so they are current while Done is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= 32'h0;
            wr_count <= 32'h0;
        end else if (go_resp && !eff_err) begin
            if (eff_store) wr_count <= wr_count + 32'd1;
            else           rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule
